can_frame_scheduler: RTL and testbench
======================================

# can_frame_scheduler

Parametrised periodic CAN transmit scheduler for the cart's vehicle-data path. It replaces the fixed two-frame engine-rev/vehicle-speed sequencer with NUM_CH independently enabled message slots, each with its own ID, payload and DLC. It retries frames that lose arbitration or fail ACK/bit monitoring, and reports per-channel failure and overrun status. It sits between the application data sources and the CAN controller's AXI4-Stream send/result ports.

## Interface
- NUM_CH, 4, number of message slots (1..16)
- PERIOD_CYCLE, 50_000_000, clk cycles per transmit period (≥ 2)
- MAX_RETRY, 2, resend attempts after a failed result before a frame is abandoned (0..15)

- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- ch_enable  in  NUM_CH  slot i is scheduled each period when bit i = 1
- ch_id  in  NUM_CH*11  slot i ID at bits [11*i +: 11]
- ch_data  in  NUM_CH*64  slot i payload at [64*i +: 64], MSB byte sent first
- ch_keep  in  NUM_CH*8  slot i byte-valid mask (DLC) at [8*i +: 8]
- stm_send_data_out_tdata  out  64  frame payload
- stm_send_data_out_tid  out  11  frame ID
- stm_send_data_out_tkeep  out  8  frame byte mask
- stm_send_data_out_tvalid  out  1
- stm_send_data_out_tready  in  1
- stm_result_in_tdata  in  3  {arbitration lost, ACK error, bit-monitor error}
- stm_result_in_tvalid  in  1
- stm_result_in_tready  out  1
- ch_fail  out  NUM_CH  bit i = 1 after slot i's last frame was abandoned
- ch_overrun  out  NUM_CH  sticky; slot i was still pending at a new period tick
- frame_count  out  16  successful frames, wraps 0xFFFF→0

## Operation
- Period counter: runs 0..PERIOD_CYCLE-1 and wraps. Tick when count == PERIOD_CYCLE-1.
- On tick: pending |= ch_enable. For any bit already pending and enabled, set ch_overrun for that bit.
- Every cycle: pending &= ch_enable. Disabling a slot drops its request, except for the frame currently in SEND/RESULT.
- States:
  - IDLE: go to SCAN when pending != 0.
  - SCAN: select the lowest-index pending slot. Snapshot its id/data/keep into output registers. Clear retry_cnt. Go to SEND. If pending == 0 (cleared by disable), return to IDLE.
  - SEND: tvalid = 1 with the snapshot held stable. On tvalid & tready, go to RESULT.
  - RESULT: tready = 1. On handshake:
    - tdata == 0: success. Clear the pending bit, clear ch_fail bit, increment frame_count, go to SCAN.
    - tdata != 0 and retry_cnt < MAX_RETRY: increment retry_cnt, go to SEND with the same snapshot.
    - tdata != 0 and retry_cnt == MAX_RETRY: clear the pending bit, set ch_fail bit, go to SCAN.
- Same-cycle tick and pending-clear for the slot in flight: the set wins, and the slot is sent again in this period. No overrun is flagged, since the in-flight bit counts as served.
- Output registers hold their values outside SEND. tdata/tid/tkeep are compared only while tvalid = 1.
- Reset (any state, including mid-handshake):
  - state = IDLE, pending = 0, period counter = 0
  - tvalid = 0, tready = 0, tdata/tid/tkeep = 0
  - ch_fail = 0, ch_overrun = 0, frame_count = 0

## Timing
- First tick occurs PERIOD_CYCLE-1 cycles after rst deasserts. Pending is visible the next cycle, then IDLE→SCAN→SEND: tvalid rises 3 cycles after the tick cycle.
- tvalid and payload stay stable until tready; no combinational path from tready to tvalid.
- Result handshake → SCAN → SEND: the next frame's tvalid rises 2 cycles after the result handshake cycle.
- Retry: the resent frame's tvalid rises 1 cycle after the failing result handshake.
- ch_fail, ch_overrun and frame_count update on the clock edge that completes the relevant handshake or tick.

## Test plan
- NUM_CH=3, PERIOD_CYCLE=100, MAX_RETRY=2, ch_enable=3'b101, result always 0 → per period, IDs of slot 0 then slot 2 with exact data/keep; frame_count +2 per period; first tvalid 3 cycles after the first tick.
- Slot 0 result 3'b100 twice then 3'b000 → slot 0 sent 3 times total, each resend 1 cycle after the result; ch_fail[0]=0; frame_count +1.
- Slot 1 result 3'b010 three times → 3 attempts, then ch_fail[1]=1 and slot 2 proceeds. Next period succeeds → ch_fail[1] clears.
- tready held low for 150 cycles on slot 0 → tvalid and payload stable throughout; ch_overrun[0] set at the tick, other bits unchanged.
- ch_enable[2] cleared while slot 0 is in RESULT → slot 2 never sent; state returns to IDLE.
- rst pulsed while in SEND → next cycle tvalid=0, frame_count=0, ch_fail=0; the schedule restarts one full period later.

Source files
------------

// File: rtl/can_frame_scheduler.sv
// Periodic CAN transmit scheduler: NUM_CH slots are requested once per period and sent
// lowest index first over an AXI4-Stream send/result pair, with bounded resend on failure.
module can_frame_scheduler #(
  parameter int NUM_CH       = 4,
  parameter int PERIOD_CYCLE = 50_000_000,
  parameter int MAX_RETRY    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CH-1:0]    ch_enable,
  input  logic [NUM_CH*11-1:0] ch_id,
  input  logic [NUM_CH*64-1:0] ch_data,
  input  logic [NUM_CH*8-1:0]  ch_keep,
  output logic [63:0]          stm_send_data_out_tdata,
  output logic [10:0]          stm_send_data_out_tid,
  output logic [7:0]           stm_send_data_out_tkeep,
  output logic                 stm_send_data_out_tvalid,
  input  logic                 stm_send_data_out_tready,
  input  logic [2:0]           stm_result_in_tdata,
  input  logic                 stm_result_in_tvalid,
  output logic                 stm_result_in_tready,
  output logic [NUM_CH-1:0]    ch_fail,
  output logic [NUM_CH-1:0]    ch_overrun,
  output logic [15:0]          frame_count
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(PERIOD_CYCLE);

  typedef enum logic [1:0] {IDLE, SCAN, SEND, RESULT} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  period_cnt;
  logic              tick;
  logic [NUM_CH-1:0] pending, pending_nxt, eff_pending;
  logic [NUM_CH-1:0] inflight_mask, done_mask, overrun_set;
  logic [IDX_W-1:0]  cur_idx, sel_idx;
  logic [3:0]        retry_cnt;
  logic              busy, result_hs, res_ok, res_retry, res_abandon;
  logic [10:0]       sel_id;
  logic [63:0]       sel_data;
  logic [7:0]        sel_keep;

  function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_CH-1:0] v);
    lowest_set = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (v[i]) lowest_set = IDX_W'(i);
  endfunction

  assign tick        = (period_cnt == CNT_W'(PERIOD_CYCLE - 1));
  assign eff_pending = pending & ch_enable;
  assign busy        = (state == SEND) || (state == RESULT);
  assign result_hs   = (state == RESULT) && stm_result_in_tvalid;
  assign res_ok      = result_hs && (stm_result_in_tdata == 3'b000);
  assign res_retry   = result_hs && (stm_result_in_tdata != 3'b000) && (retry_cnt < 4'(MAX_RETRY));
  assign res_abandon = result_hs && (stm_result_in_tdata != 3'b000) && !(retry_cnt < 4'(MAX_RETRY));

  always_comb begin
    sel_idx  = lowest_set(eff_pending);
    sel_id   = '0;
    sel_data = '0;
    sel_keep = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel_idx == IDX_W'(i)) begin
        sel_id   = ch_id[11*i +: 11];
        sel_data = ch_data[64*i +: 64];
        sel_keep = ch_keep[8*i +: 8];
      end
    end
  end

  // The in-flight slot survives a disable; a tick on the same edge as its clear re-requests it
  // and does not count as an overrun because the frame just completed.
  always_comb begin
    inflight_mask = '0;
    for (int i = 0; i < NUM_CH; i++)
      inflight_mask[i] = busy && (cur_idx == IDX_W'(i));
    done_mask   = (res_ok || res_abandon) ? inflight_mask : '0;
    overrun_set = tick ? (pending & ch_enable & ~done_mask) : '0;
    pending_nxt = (pending & (ch_enable | inflight_mask) & ~done_mask) | (tick ? ch_enable : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt                = state;
    stm_send_data_out_tvalid = 1'b0;
    stm_result_in_tready     = 1'b0;
    case (state)
      IDLE:   if (pending != '0) state_nxt = SCAN;
      SCAN:   state_nxt = (eff_pending != '0) ? SEND : IDLE;
      SEND: begin
        stm_send_data_out_tvalid = 1'b1;
        if (stm_send_data_out_tready) state_nxt = RESULT;
      end
      RESULT: begin
        stm_result_in_tready = 1'b1;
        if (res_retry)                  state_nxt = SEND;
        else if (res_ok || res_abandon) state_nxt = SCAN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      period_cnt              <= '0;
      pending                 <= '0;
      cur_idx                 <= '0;
      retry_cnt               <= '0;
      stm_send_data_out_tdata <= '0;
      stm_send_data_out_tid   <= '0;
      stm_send_data_out_tkeep <= '0;
      ch_fail                 <= '0;
      ch_overrun              <= '0;
      frame_count             <= '0;
    end else begin
      period_cnt <= tick ? '0 : period_cnt + CNT_W'(1);
      pending    <= pending_nxt;
      ch_overrun <= ch_overrun | overrun_set;
      // Snapshot stays frozen through SEND/RESULT and every resend.
      if (state == SCAN && eff_pending != '0) begin
        cur_idx                 <= sel_idx;
        stm_send_data_out_tid   <= sel_id;
        stm_send_data_out_tdata <= sel_data;
        stm_send_data_out_tkeep <= sel_keep;
        retry_cnt               <= '0;
      end
      if (res_retry) retry_cnt <= retry_cnt + 4'd1;
      if (res_ok) frame_count <= frame_count + 16'd1;
      ch_fail <= (ch_fail & ~(res_ok ? inflight_mask : '0)) | (res_abandon ? inflight_mask : '0);
    end
  end

endmodule

// File: tb/tb_can_frame_scheduler.sv
// Scoreboard bench for can_frame_scheduler: expected frames are queued when a period is set up
// and popped as the DUT presents each frame; result codes are answered by the bench.
module tb_can_frame_scheduler;
  localparam int NUM_CH = 3;
  localparam int PERIOD = 100;
  localparam int MAX_RETRY = 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NUM_CH-1:0]    ch_enable;
  logic [NUM_CH*11-1:0] ch_id;
  logic [NUM_CH*64-1:0] ch_data;
  logic [NUM_CH*8-1:0]  ch_keep;
  logic [63:0]          tdata;
  logic [10:0]          tid;
  logic [7:0]           tkeep;
  logic                 tvalid, tready;
  logic [2:0]           rdata;
  logic                 rvalid, rready;
  logic [NUM_CH-1:0]    ch_fail, ch_overrun;
  logic [15:0]          frame_count;

  typedef struct packed {
    logic [10:0] id;
    logic [63:0] data;
    logic [7:0]  keep;
  } frm_t;

  frm_t slot_tab [NUM_CH];
  frm_t exp_q[$];
  int   checks = 0, failures = 0;
  int   cyc = 0, c0 = 0, exp_fc = 0, valid_cyc = 0, res_cyc = 0, prev_res = 0;

  can_frame_scheduler #(
    .NUM_CH(NUM_CH), .PERIOD_CYCLE(PERIOD), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk), .rst(rst), .ch_enable(ch_enable), .ch_id(ch_id), .ch_data(ch_data), .ch_keep(ch_keep),
    .stm_send_data_out_tdata(tdata), .stm_send_data_out_tid(tid), .stm_send_data_out_tkeep(tkeep),
    .stm_send_data_out_tvalid(tvalid), .stm_send_data_out_tready(tready),
    .stm_result_in_tdata(rdata), .stm_result_in_tvalid(rvalid), .stm_result_in_tready(rready),
    .ch_fail(ch_fail), .ch_overrun(ch_overrun), .frame_count(frame_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    ch_id   = '0;
    ch_data = '0;
    ch_keep = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_id[11*i +: 11]  = slot_tab[i].id;
      ch_data[64*i +: 64] = slot_tab[i].data;
      ch_keep[8*i +: 8]  = slot_tab[i].keep;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic expect_slot(input int s);
    exp_q.push_back(slot_tab[s]);
  endtask

  // Entered and left on a falling edge. Accepts one frame (optionally after a stall), then
  // answers it with res, applying en_res to ch_enable while the result is pending.
  task automatic serve(input logic [2:0] res, input int stall, input logic [NUM_CH-1:0] en_res);
    frm_t e;
    int   n;
    logic stable;
    n = 0;
    while (tvalid !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    if (tvalid !== 1'b1) begin chk("valid_timeout", 64'd0, 64'd1); return; end
    valid_cyc = cyc;
    if (exp_q.size() == 0) begin chk("unexpected_frame", 64'd1, 64'd0); e = '0; end
    else e = exp_q.pop_front();
    chk("tid", 64'(tid), 64'(e.id));
    chk("tdata", tdata, e.data);
    chk("tkeep", 64'(tkeep), 64'(e.keep));
    if (stall > 0) begin
      stable = 1'b1;
      for (int k = 0; k < stall; k++) begin
        @(negedge clk);
        if (tvalid !== 1'b1 || tid !== e.id || tdata !== e.data || tkeep !== e.keep) stable = 1'b0;
      end
      chk("stall_stable", 64'(stable), 64'd1);
    end
    tready = 1'b1;
    @(negedge clk);
    tready = 1'b0;
    n = 0;
    while (rready !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    if (rready !== 1'b1) begin chk("rready_timeout", 64'd0, 64'd1); return; end
    ch_enable = en_res;
    res_cyc = cyc;
    rdata = res;
    rvalid = 1'b1;
    @(negedge clk);
    rvalid = 1'b0;
    rdata = 3'b000;
    if (res == 3'b000) exp_fc++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "bench watchdog");
  end

  initial begin
    int  n;
    int  saw;
    slot_tab[0] = '{id: 11'h100, data: 64'h0123_4567_89AB_CDEF, keep: 8'hFF};
    slot_tab[1] = '{id: 11'h2A5, data: 64'hDEAD_BEEF_0000_1234, keep: 8'h0F};
    slot_tab[2] = '{id: 11'h7FF, data: 64'h8000_0000_0000_0001, keep: 8'h01};
    ch_enable = '0;
    tready = 1'b0;
    rvalid = 1'b0;
    rdata = 3'b000;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tvalid", 64'(tvalid), 64'd0);
    chk("rst_rready", 64'(rready), 64'd0);
    chk("rst_fc", 64'(frame_count), 64'd0);
    chk("rst_fail", 64'(ch_fail), 64'd0);
    chk("rst_ovr", 64'(ch_overrun), 64'd0);
    chk("rst_tdata", tdata, 64'd0);

    // Two periods of slots 0 and 2, all successful.
    ch_enable = 3'b101;
    rst = 1'b0;
    c0 = cyc;
    expect_slot(0); expect_slot(2);
    serve(3'b000, 0, ch_enable);
    chk("first_latency", 64'(valid_cyc - c0), 64'(PERIOD - 1 + 3));
    prev_res = res_cyc;
    serve(3'b000, 0, ch_enable);
    chk("next_latency", 64'(valid_cyc - prev_res), 64'd2);
    chk("fc_p1", 64'(frame_count), 64'(exp_fc));
    expect_slot(0); expect_slot(2);
    serve(3'b000, 0, ch_enable);
    serve(3'b000, 0, ch_enable);
    chk("fc_p2", 64'(frame_count), 64'(exp_fc));

    // Arbitration lost twice on slot 0, then success.
    expect_slot(0); expect_slot(0); expect_slot(0); expect_slot(2);
    serve(3'b100, 0, ch_enable);
    prev_res = res_cyc;
    serve(3'b100, 0, ch_enable);
    chk("retry_lat1", 64'(valid_cyc - prev_res), 64'd1);
    prev_res = res_cyc;
    serve(3'b000, 0, ch_enable);
    chk("retry_lat2", 64'(valid_cyc - prev_res), 64'd1);
    chk("fail0_clear", 64'(ch_fail), 64'd0);
    chk("fc_retry", 64'(frame_count), 64'(exp_fc));
    serve(3'b000, 0, ch_enable);

    // Slot 1 fails ACK on every attempt and is abandoned; next period recovers.
    ch_enable = 3'b111;
    expect_slot(0); expect_slot(1); expect_slot(1); expect_slot(1); expect_slot(2);
    serve(3'b000, 0, ch_enable);
    serve(3'b010, 0, ch_enable);
    serve(3'b010, 0, ch_enable);
    serve(3'b010, 0, ch_enable);
    chk("fail1_set", 64'(ch_fail), 64'b010);
    serve(3'b000, 0, ch_enable);
    chk("fc_abandon", 64'(frame_count), 64'(exp_fc));
    expect_slot(0); expect_slot(1); expect_slot(2);
    serve(3'b000, 0, ch_enable);
    serve(3'b000, 0, ch_enable);
    serve(3'b000, 0, ch_enable);
    chk("fail1_clear", 64'(ch_fail), 64'd0);
    chk("fc_recover", 64'(frame_count), 64'(exp_fc));

    // Slot 0 stalled across a tick.
    ch_enable = 3'b001;
    chk("ovr_none", 64'(ch_overrun), 64'd0);
    expect_slot(0);
    serve(3'b000, 150, ch_enable);
    chk("ovr_slot0", 64'(ch_overrun), 64'b001);
    chk("fc_stall", 64'(frame_count), 64'(exp_fc));

    // Slot 2 disabled while slot 0 awaits its result.
    ch_enable = 3'b101;
    expect_slot(0);
    serve(3'b000, 0, 3'b001);
    saw = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (tvalid === 1'b1 || rready === 1'b1) saw = 1;
    end
    chk("dis_no_send", 64'(saw), 64'd0);
    chk("fc_dis", 64'(frame_count), 64'(exp_fc));

    // Reset while a frame is offered.
    ch_enable = 3'b101;
    n = 0;
    while (tvalid !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    chk("rst_mid_valid", 64'(tvalid), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_tvalid", 64'(tvalid), 64'd0);
    chk("rst_mid_fc", 64'(frame_count), 64'd0);
    chk("rst_mid_fail", 64'(ch_fail), 64'd0);
    chk("rst_mid_ovr", 64'(ch_overrun), 64'd0);
    chk("rst_mid_tid", 64'(tid), 64'd0);
    rst = 1'b0;
    c0 = cyc;
    exp_fc = 0;
    expect_slot(0); expect_slot(2);
    serve(3'b000, 0, ch_enable);
    chk("restart_latency", 64'(valid_cyc - c0), 64'(PERIOD - 1 + 3));
    serve(3'b000, 0, ch_enable);
    chk("fc_restart", 64'(frame_count), 64'(exp_fc));
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
